// File: rtl/sram_axi_bridge_if.sv
// Bundle of the CPU SRAM-like ports and the packed AXI channels seen by sram_axi_bridge.
// Every *_valid/*_ready pair transfers on a rising clk edge where both are high; valid and payload hold until then.
interface sram_axi_bridge_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        ar_valid;
    logic        ar_ready;
    logic [38:0] ar_payload;
    logic        r_valid;
    logic        r_ready;
    logic [35:0] r_payload;
    logic        aw_valid;
    logic        aw_ready;
    logic [34:0] aw_payload;
    logic        w_valid;
    logic        w_ready;
    logic [35:0] w_payload;
    logic        b_valid;
    logic        b_ready;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output ar_valid, ar_payload, input ar_ready,
        input  r_valid, r_payload, output r_ready,
        output aw_valid, aw_payload, input aw_ready,
        output w_valid, w_payload, input w_ready,
        input  b_valid, output b_ready
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  ar_valid, ar_payload, output ar_ready,
        output r_valid, r_payload, input r_ready,
        input  aw_valid, aw_payload, output aw_ready,
        input  w_valid, w_payload, output w_ready,
        output b_valid, input b_ready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Joins the CPU instruction (read-only) and data (read/write) SRAM-like ports onto one packed AXI master.
// Each side keeps at most one transaction outstanding; reads stall behind an in-flight write to the same word.
module sram_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic              clk,
    input  logic              reset,
    sram_axi_bridge_if.master bus,
    output logic              dbg_r_state_o,
    output logic [1:0]        dbg_w_state_o
);

    typedef enum logic {R_IDLE = 1'b0, R_ADDR = 1'b1} r_state_e;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_SEND = 2'd1, W_RESP = 2'd2} w_state_e;

    r_state_e    r_state_q, r_state_d;
    w_state_e    w_state_q, w_state_d;
    logic        inst_pend_q, inst_pend_d;
    logic        data_pend_q, data_pend_d;
    logic [38:0] ar_payload_q, ar_payload_d;
    logic [34:0] aw_payload_q, aw_payload_d;
    logic [35:0] w_payload_q, w_payload_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        r_ready_q;
    logic        inst_data_ok_q, inst_data_ok_d;
    logic        data_data_ok_q, data_data_ok_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    logic        ld_req, st_req, wr_busy, rd_idle;
    logic        ld_hit, if_hit;
    logic        ld_acc, if_acc, st_acc;
    logic        r_fire;
    logic [3:0]  rid;

    assign ld_req  = bus.data_req & ~bus.data_wr;
    assign st_req  = bus.data_req & bus.data_wr;
    assign wr_busy = (w_state_q != W_IDLE);
    assign rd_idle = ~reset & (r_state_q == R_IDLE);

    // A fetch also yields to a store to the same word that is being accepted this very cycle.
    assign st_acc = ~reset & (w_state_q == W_IDLE) & st_req & ~data_pend_q;
    assign ld_hit = wr_busy & (aw_payload_q[31:2] == bus.data_addr[31:2]);
    assign if_hit = (wr_busy & (aw_payload_q[31:2] == bus.inst_addr[31:2]))
                  | (st_acc & (bus.data_addr[31:2] == bus.inst_addr[31:2]));

    // The load wins the read slot even when it is blocked; the fetch only goes when no load is asking.
    assign ld_acc = rd_idle & ld_req & ~data_pend_q & ~ld_hit;
    assign if_acc = rd_idle & ~ld_req & bus.inst_req & ~inst_pend_q & ~if_hit;

    assign r_fire = bus.r_valid & r_ready_q;
    assign rid    = bus.r_payload[35:32];

    assign bus.inst_addr_ok = if_acc;
    assign bus.data_addr_ok = ld_acc | st_acc;
    assign bus.inst_data_ok = inst_data_ok_q;
    assign bus.data_data_ok = data_data_ok_q;
    assign bus.inst_rdata   = inst_rdata_q;
    assign bus.data_rdata   = data_rdata_q;
    assign bus.ar_valid     = (r_state_q == R_ADDR);
    assign bus.ar_payload   = ar_payload_q;
    assign bus.r_ready      = r_ready_q;
    assign bus.aw_valid     = aw_valid_q;
    assign bus.aw_payload   = aw_payload_q;
    assign bus.w_valid      = w_valid_q;
    assign bus.w_payload    = w_payload_q;
    assign bus.b_ready      = (w_state_q == W_RESP);

    assign dbg_r_state_o = r_state_q;
    assign dbg_w_state_o = w_state_q;

    always_comb begin
        r_state_d      = r_state_q;
        w_state_d      = w_state_q;
        inst_pend_d    = inst_pend_q;
        data_pend_d    = data_pend_q;
        ar_payload_d   = ar_payload_q;
        aw_payload_d   = aw_payload_q;
        w_payload_d    = w_payload_q;
        aw_valid_d     = aw_valid_q;
        w_valid_d      = w_valid_q;
        inst_data_ok_d = 1'b0;
        data_data_ok_d = 1'b0;
        inst_rdata_d   = inst_rdata_q;
        data_rdata_d   = data_rdata_q;

        // Read data is steered by rid; unknown ids fall through untouched.
        if (r_fire) begin
            if (rid == INST_ID) begin
                inst_rdata_d   = bus.r_payload[31:0];
                inst_data_ok_d = 1'b1;
                inst_pend_d    = 1'b0;
            end else if (rid == DATA_ID) begin
                data_rdata_d   = bus.r_payload[31:0];
                data_data_ok_d = 1'b1;
                data_pend_d    = 1'b0;
            end
        end

        case (r_state_q)
            R_IDLE: begin
                if (ld_acc) begin
                    ar_payload_d = {DATA_ID, 1'b0, bus.data_size, bus.data_addr};
                    data_pend_d  = 1'b1;
                    r_state_d    = R_ADDR;
                end else if (if_acc) begin
                    ar_payload_d = {INST_ID, 3'b010, bus.inst_addr};
                    inst_pend_d  = 1'b1;
                    r_state_d    = R_ADDR;
                end
            end
            R_ADDR: begin
                if (bus.ar_ready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase

        case (w_state_q)
            W_IDLE: begin
                if (st_acc) begin
                    aw_payload_d = {1'b0, bus.data_size, bus.data_addr};
                    w_payload_d  = {bus.data_wstrb, bus.data_wdata};
                    aw_valid_d   = 1'b1;
                    w_valid_d    = 1'b1;
                    data_pend_d  = 1'b1;
                    w_state_d    = W_SEND;
                end
            end
            W_SEND: begin
                if (aw_valid_q & bus.aw_ready) aw_valid_d = 1'b0;
                if (w_valid_q & bus.w_ready)   w_valid_d  = 1'b0;
                if (~aw_valid_d & ~w_valid_d)  w_state_d  = W_RESP;
            end
            W_RESP: begin
                if (bus.b_valid) begin
                    data_data_ok_d = 1'b1;
                    data_pend_d    = 1'b0;
                    w_state_d      = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q      <= R_IDLE;
            w_state_q      <= W_IDLE;
            inst_pend_q    <= 1'b0;
            data_pend_q    <= 1'b0;
            ar_payload_q   <= '0;
            aw_payload_q   <= '0;
            w_payload_q    <= '0;
            aw_valid_q     <= 1'b0;
            w_valid_q      <= 1'b0;
            r_ready_q      <= 1'b0;
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            inst_rdata_q   <= '0;
            data_rdata_q   <= '0;
        end else begin
            r_state_q      <= r_state_d;
            w_state_q      <= w_state_d;
            inst_pend_q    <= inst_pend_d;
            data_pend_q    <= data_pend_d;
            ar_payload_q   <= ar_payload_d;
            aw_payload_q   <= aw_payload_d;
            w_payload_q    <= w_payload_d;
            aw_valid_q     <= aw_valid_d;
            w_valid_q      <= w_valid_d;
            r_ready_q      <= 1'b1;
            inst_data_ok_q <= inst_data_ok_d;
            data_data_ok_q <= data_data_ok_d;
            inst_rdata_q   <= inst_rdata_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

endmodule
